// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/pf_fifo.sv
// DEPTH x 64-bit synchronous FIFO holding {pc, instr}; flush empties it and
// wins over push and pop in the same edge.
module pf_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          CLR,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata,
    output logic [CW-1:0] cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [63:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] cnt_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify push/pop: flush overrides both, pop needs a non-empty queue.
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush) begin
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end else begin
            do_push_s = push;
            do_pop_s  = pop & (cnt_r != {CW{1'b0}});
        end
    end

    // Storage array; left unreset so it can map onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (do_push_s && !CLR) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (CLR || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign cnt   = cnt_r;

    pf_fifo_chk #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk   (clk),
        .CLR   (CLR),
        .push  (do_push_s),
        .pop   (do_pop_s),
        .flush (flush),
        .cnt   (cnt_r)
    );

endmodule

// File: rtl/pf_fifo_chk.sv
// Simulation-only checks on the prefetch queue: no overflow, count in range.
module pf_fifo_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input logic          clk,
    input logic          CLR,
    input logic          push,
    input logic          pop,
    input logic          flush,
    input logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    a_no_overflow: assert property (@(posedge clk) disable iff (CLR)
        (push && !flush && (cnt == DEPTH_C)) |-> pop)
        else $error("pf_fifo: push while full");

    a_cnt_range: assert property (@(posedge clk) disable iff (CLR)
        cnt <= DEPTH_C)
        else $error("pf_fifo: occupancy above depth");

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: sequential prefetch into a small queue with
// flush/redirect on taken branches (EX) and jumps (ID).
module if_prefetch
    import if_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    CLR,
    output logic                    imem_req,
    output logic [31:0]             imem_addr,
    input  logic                    imem_ack,
    input  logic [31:0]             imem_rdata,
    input  logic                    B,
    input  logic [31:0]             baddr,
    input  logic                    JMP,
    input  logic                    JAL,
    input  logic                    JR,
    input  logic [31:0]             jaddr,
    input  logic                    id_ready,
    output logic [31:0]             IR,
    output logic [31:0]             PC,
    output logic                    if_valid,
    output logic [$clog2(DEPTH):0]  queue_cnt
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_e  state_r;
    logic [31:0]   fpc_r;
    logic [31:0]   req_addr_r;

    logic          redirect_s;
    logic [31:0]   target_s;
    logic          pop_s;
    logic          push_s;
    logic          valid_s;
    logic          space_s;
    logic          space_after_s;
    logic [CW-1:0] fifo_cnt_s;
    logic [CW-1:0] cnt_less_pop_s;
    logic [63:0]   head_s;
    logic [31:0]   fpc_next_s;

    // Redirect decode, pop/push qualification and queue space look-ahead.
    always_comb begin
        redirect_s = B | JMP | JAL | JR;
        // EX is older than ID, so the branch target wins.
        if (B) begin
            target_s = baddr;
        end else begin
            target_s = jaddr;
        end
        valid_s        = (fifo_cnt_s != {CW{1'b0}});
        pop_s          = valid_s & id_ready & ~redirect_s;
        push_s         = (state_r == REQ) & imem_ack & ~redirect_s;
        cnt_less_pop_s = fifo_cnt_s - {{(CW-1){1'b0}}, pop_s};
        space_s        = (cnt_less_pop_s < DEPTH_C);
        space_after_s  = ((cnt_less_pop_s + CW'(1)) < DEPTH_C);
        fpc_next_s     = fpc_r + PC_STEP;
    end

    // Fetch FSM; in REQ req_addr always equals fpc, so pushes tag with fpc.
    always_ff @(posedge clk) begin
        if (CLR) begin
            state_r    <= IDLE;
            fpc_r      <= RESET_PC;
            req_addr_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (redirect_s) begin
                        fpc_r      <= target_s;
                        req_addr_r <= target_s;
                        state_r    <= REQ;
                    end else if (space_s) begin
                        req_addr_r <= fpc_r;
                        state_r    <= REQ;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                REQ: begin
                    if (imem_ack && !redirect_s) begin
                        fpc_r <= fpc_next_s;
                        if (space_after_s) begin
                            req_addr_r <= fpc_next_s;
                            state_r    <= REQ;
                        end else begin
                            state_r    <= IDLE;
                        end
                    end else if (imem_ack && redirect_s) begin
                        fpc_r      <= target_s;
                        req_addr_r <= target_s;
                        state_r    <= REQ;
                    end else if (redirect_s) begin
                        // Outstanding request must finish before the new one.
                        fpc_r   <= target_s;
                        state_r <= DROP;
                    end else begin
                        state_r <= REQ;
                    end
                end
                DROP: begin
                    if (redirect_s) begin
                        fpc_r <= target_s;
                    end
                    if (imem_ack) begin
                        req_addr_r <= redirect_s ? target_s : fpc_r;
                        state_r    <= REQ;
                    end else begin
                        state_r    <= DROP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    pf_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .CLR   (CLR),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect_s),
        .wdata ({fpc_r, imem_rdata}),
        .rdata (head_s),
        .cnt   (fifo_cnt_s)
    );

    // Present queue head, or a NOP with PC 0 while empty.
    always_comb begin
        if (valid_s) begin
            IR = head_s[31:0];
            PC = head_s[63:32];
        end else begin
            IR = NOP_INSTR;
            PC = 32'h0000_0000;
        end
    end

    assign imem_req  = (state_r != IDLE);
    assign imem_addr = req_addr_r;
    assign if_valid  = valid_s;
    assign queue_cnt = fifo_cnt_s;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch with a configurable-latency memory responder.
module tb_if_prefetch;

    logic        clk = 1'b0;
    logic        CLR;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        B;
    logic [31:0] baddr;
    logic        JMP;
    logic        JAL;
    logic        JR;
    logic [31:0] jaddr;
    logic        id_ready;
    logic [31:0] IR;
    logic [31:0] PC;
    logic        if_valid;
    logic [2:0]  queue_cnt;

    int checks = 0;
    int errors = 0;

    logic        manual = 1'b0;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = 32'h0;
    logic        auto_ack = 1'b0;
    logic [31:0] auto_rdata = 32'h0;
    int          lat = 0;
    int          wcnt = 0;

    assign imem_ack   = manual ? man_ack : auto_ack;
    assign imem_rdata = manual ? man_rdata : auto_rdata;

    if_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .CLR(CLR), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .B(B), .baddr(baddr),
        .JMP(JMP), .JAL(JAL), .JR(JR), .jaddr(jaddr), .id_ready(id_ready),
        .IR(IR), .PC(PC), .if_valid(if_valid), .queue_cnt(queue_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    // Memory responder: acks after 'lat' wait cycles of a held request.
    initial begin
        forever begin
            @(negedge clk);
            if (CLR || !imem_req) begin
                auto_ack = 1'b0;
                wcnt = 0;
            end else if (wcnt >= lat) begin
                auto_ack = 1'b1;
                auto_rdata = mem_word(imem_addr);
                wcnt = 0;
            end else begin
                auto_ack = 1'b0;
                wcnt = wcnt + 1;
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        CLR = 1'b1; B = 1'b0; JMP = 1'b0; JAL = 1'b0; JR = 1'b0;
        baddr = 32'h0; jaddr = 32'h0; id_ready = 1'b0;
        step();
        step();
        CLR = 1'b0;
    endtask

    task automatic test_reset();
        CLR = 1'b1; B = 1'b0; JMP = 1'b0; JAL = 1'b0; JR = 1'b0;
        baddr = 32'h0; jaddr = 32'h0; id_ready = 1'b1; lat = 0;
        step();
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
        checks++; if (IR !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h expected 0", IR); end
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", PC); end
        checks++; if (queue_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", queue_cnt); end
        CLR = 1'b0;
    endtask

    task automatic test_sequential();
        lat = 0;
        do_reset();
        id_ready = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL seq_first_req: got req=%b addr=%h expected 1/0", imem_req, imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL seq_not_yet_valid: got %b expected 0", if_valid); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (PC !== 32'(4 * k) || IR !== mem_word(32'(4 * k))) begin errors++; $display("FAIL seq_head%0d: got PC=%h IR=%h expected %h/%h", k, PC, IR, 32'(4 * k), mem_word(32'(4 * k))); end
            checks++; if (imem_addr !== 32'(4 * k + 4)) begin errors++; $display("FAIL seq_addr%0d: got %h expected %h", k, imem_addr, 32'(4 * k + 4)); end
            checks++; if (queue_cnt !== 3'd1) begin errors++; $display("FAIL seq_cnt%0d: got %0d expected 1", k, queue_cnt); end
        end
    endtask

    task automatic test_fill();
        lat = 0;
        do_reset();
        id_ready = 1'b0;
        for (int k = 0; k < 7; k++) step();
        checks++; if (queue_cnt !== 3'd4) begin errors++; $display("FAIL fill_cnt: got %0d expected 4", queue_cnt); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fill_req_drop: got %b expected 0", imem_req); end
        checks++; if (PC !== 32'h0 || IR !== mem_word(32'h0)) begin errors++; $display("FAIL fill_head: got PC=%h IR=%h expected 0/%h", PC, IR, mem_word(32'h0)); end
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL fill_refetch: got req=%b addr=%h expected 1/10", imem_req, imem_addr); end
        checks++; if (queue_cnt !== 3'd3 || PC !== 32'h4) begin errors++; $display("FAIL fill_after_pop: got cnt=%0d PC=%h expected 3/4", queue_cnt, PC); end
        step();
        checks++; if (queue_cnt !== 3'd4 || imem_req !== 1'b0) begin errors++; $display("FAIL fill_refill: got cnt=%0d req=%b expected 4/0", queue_cnt, imem_req); end
        step();
        step();
        checks++; if (queue_cnt !== 3'd4 || imem_req !== 1'b0) begin errors++; $display("FAIL fill_single_fetch: got cnt=%0d req=%b expected 4/0", queue_cnt, imem_req); end
    endtask

    task automatic test_latency_jump();
        lat = 3;
        do_reset();
        id_ready = 1'b1;
        step();
        step();
        JMP = 1'b1; jaddr = 32'h100;
        step();
        JMP = 1'b0; jaddr = 32'h0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL jmp_addr_held: got req=%b addr=%h expected 1/0", imem_req, imem_addr); end
        step();
        checks++; if (imem_addr !== 32'h0 || if_valid !== 1'b0) begin errors++; $display("FAIL jmp_wait_ack: got addr=%h valid=%b expected 0/0", imem_addr, if_valid); end
        step();
        checks++; if (imem_addr !== 32'h100 || if_valid !== 1'b0 || IR !== 32'h0) begin errors++; $display("FAIL jmp_dropped: got addr=%h valid=%b IR=%h expected 100/0/0", imem_addr, if_valid, IR); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL jmp_wait%0d: got valid=%b expected 0", k, if_valid); end
        end
        step();
        checks++; if (if_valid !== 1'b1 || PC !== 32'h100 || IR !== mem_word(32'h100)) begin errors++; $display("FAIL jmp_target: got valid=%b PC=%h IR=%h expected 1/100/%h", if_valid, PC, IR, mem_word(32'h100)); end
        lat = 0;
    endtask

    task automatic test_branch_priority();
        lat = 0;
        do_reset();
        id_ready = 1'b0;
        step();
        step();
        step();
        checks++; if (queue_cnt !== 3'd2) begin errors++; $display("FAIL bpri_prefill: got %0d expected 2", queue_cnt); end
        B = 1'b1; baddr = 32'h40; JR = 1'b1; jaddr = 32'h80;
        step();
        B = 1'b0; JR = 1'b0; id_ready = 1'b1;
        checks++; if (queue_cnt !== 3'd0 || imem_addr !== 32'h40) begin errors++; $display("FAIL bpri_flush: got cnt=%0d addr=%h expected 0/40", queue_cnt, imem_addr); end
        step();
        checks++; if (PC !== 32'h40 || IR !== mem_word(32'h40)) begin errors++; $display("FAIL bpri_target: got PC=%h IR=%h expected 40/%h", PC, IR, mem_word(32'h40)); end
    endtask

    task automatic test_redirect_pop();
        lat = 0;
        do_reset();
        id_ready = 1'b0;
        step();
        step();
        step();
        JMP = 1'b1; jaddr = 32'h200; id_ready = 1'b1;
        step();
        JMP = 1'b0;
        checks++; if (queue_cnt !== 3'd0 || if_valid !== 1'b0) begin errors++; $display("FAIL rpop_flush: got cnt=%0d valid=%b expected 0/0", queue_cnt, if_valid); end
        checks++; if (IR !== 32'h0 || PC !== 32'h0) begin errors++; $display("FAIL rpop_nop: got IR=%h PC=%h expected 0/0", IR, PC); end
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL rpop_addr: got %h expected 200", imem_addr); end
        step();
        checks++; if (PC !== 32'h200 || IR !== mem_word(32'h200)) begin errors++; $display("FAIL rpop_target: got PC=%h IR=%h expected 200/%h", PC, IR, mem_word(32'h200)); end
    endtask

    task automatic test_clr_midtxn();
        manual = 1'b1; man_ack = 1'b0;
        do_reset();
        id_ready = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL clr_req_pending: got %b expected 1", imem_req); end
        CLR = 1'b1;
        step();
        checks++; if (imem_req !== 1'b0 || queue_cnt !== 3'd0) begin errors++; $display("FAIL clr_abort: got req=%b cnt=%0d expected 0/0", imem_req, queue_cnt); end
        CLR = 1'b0; man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
        step();
        man_ack = 1'b0;
        checks++; if (queue_cnt !== 3'd0 || if_valid !== 1'b0) begin errors++; $display("FAIL clr_ack_ignored: got cnt=%0d valid=%b expected 0/0", queue_cnt, if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL clr_refetch: got req=%b addr=%h expected 1/0", imem_req, imem_addr); end
        man_ack = 1'b1; man_rdata = mem_word(32'h0);
        step();
        man_ack = 1'b0;
        checks++; if (PC !== 32'h0 || IR !== mem_word(32'h0) || if_valid !== 1'b1) begin errors++; $display("FAIL clr_first: got PC=%h IR=%h valid=%b expected 0/%h/1", PC, IR, if_valid, mem_word(32'h0)); end
        manual = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_fill();
        test_latency_jump();
        test_branch_priority();
        test_redirect_pop();
        test_clr_midtxn();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
